regfile_mp_scoreboard: RTL and testbench
========================================

Name: regfile_mp_scoreboard

Overview:
Parametrised successor to the single-write register file for the dual-writeback pipeline. Provides configurable data width and depth, NUM_RD read ports and two write ports, with write-through bypass on every read port. Adds a per-register busy scoreboard: decode marks a destination pending, writeback clears it, and hazard logic reads the busy bit on each read port. A hard-wired zero register is optional.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and never becomes busy

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
rd_addr  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data, combinational, with bypass
rd_busy  output  NUM_RD  pending-write flag per read port, combinational
we0  input  1  write enable, port 0 (ALU writeback)
waddr0  input  ADDR_W  write address, port 0
wdata0  input  DATA_W  write data, port 0
we1  input  1  write enable, port 1 (load writeback)
waddr1  input  ADDR_W  write address, port 1
wdata1  input  DATA_W  write data, port 1
busy_set  input  1  mark busy_addr as pending at next edge
busy_addr  input  ADDR_W  register to mark pending
flush  input  1  clear all busy bits at next edge; data is unaffected
busy_any  output  1  registered OR of all busy bits

Behaviour:
- Reset (reset==0, asynchronous): all registers go to 0, all busy bits go to 0, busy_any goes to 0. While in reset, rd_data reads 0 and rd_busy reads 0.
- Writes take effect on the rising clk edge. A write to address 0 is dropped when ZERO_REG=1.
- Both ports writing the same address in the same cycle: port 1 wins, and the port 0 data is discarded.
- Reads are combinational with zero latency. For each read port k, evaluate in this order:
  1. ZERO_REG && addr==0 -> 0
  2. we1 && waddr1==addr -> wdata1
  3. we0 && waddr0==addr -> wdata0
  4. otherwise the stored value
- Bypass applies only when the matching write enable is high. An address match with the enable low must return the stored value.
- Busy bit update at the clock edge, per address a:
  - set when busy_set && busy_addr==a
  - cleared when (we0 && waddr0==a) or (we1 && waddr1==a)
  - set and clear on the same address in the same cycle: set wins, because a new producer was issued.
  - flush clears every bit and overrides busy_set in the same cycle.
  - with ZERO_REG=1, address 0 is never set.
- rd_busy[k] = busy[addr_k] AND NOT (a write to addr_k this cycle on either port). A same-cycle busy_set does not affect rd_busy until the next cycle.
- busy_any is registered and reflects the busy vector after the current edge's update, so it is valid one cycle after the causing event. It is 0 after a flush edge.
- Reset mid-operation: pending writes and busy_set in that cycle are lost, and the state is all zero on release.
- Deassertion of reset is synchronous to clk at the integration level. The block needs no internal synchroniser.

Test Plan:
- Reset then read: hold reset=0, then release it; read regs 0..31 on all ports -> rd_data=0, rd_busy=0, busy_any=0.
- Basic write/read: cycle 1 we0=1, waddr0=5, wdata0=0xDEADBEEF. In cycle 1 rd_addr[0]=5 -> 0xDEADBEEF via bypass; cycle 2 with we0=0 -> 0xDEADBEEF from storage. A write of 0x1234 to reg 0 -> reg 0 still reads 0.
- Dual-write collision: we0=we1=1, both waddr=7, wdata0=0x11, wdata1=0x22 -> same-cycle read of 7 gives 0x22; next cycle gives 0x22. Also check: we0=0 with waddr0=9 matching the read address -> stored value, not wdata0.
- Scoreboard: busy_set to reg 3 -> next cycle rd_busy=1 and busy_any=1. we1 to reg 3 -> rd_busy=0 in that same cycle; the bit is clear after the edge and busy_any=0 one cycle later.
- Set/clear race and flush:
  - busy_set reg 4 together with we0 to reg 4 -> busy stays 1.
  - busy_set reg 6 together with flush -> all busy bits 0.
  - busy_set reg 0 -> never busy.
- Async reset mid-op: regs hold nonzero values and busy bits are set; drop reset between clock edges -> outputs go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/regfile_mp_scoreboard.sv
// Multi-ported register file for the dual-writeback pipeline.
// Two write ports (port 1 has priority), NUM_RD combinational read ports
// with write-through bypass, an optional hard-wired zero register, and a
// per-register busy scoreboard that hazard logic can query on every read port.
module regfile_mp_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    input  logic                     flush,
    output logic                     busy_any
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              busy_any_r;
    logic              wr0_ok;
    logic              wr1_ok;

    // True when the address is the hard-wired zero register.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // A write port matches an address only while its enable is high.
    function automatic logic wr_hit(input logic en,
                                    input logic [ADDR_W-1:0] wa,
                                    input logic [ADDR_W-1:0] a);
        return en && (wa == a);
    endfunction

    // Writes aimed at the zero register are dropped before they reach storage.
    always_comb begin
        wr0_ok = we0 && !is_zero_reg(waddr0);
        wr1_ok = we1 && !is_zero_reg(waddr1);
    end

    // Storage update; port 1 is applied last so it wins an address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                regs[waddr0] <= wdata0;
            end
            if (wr1_ok) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    // Next busy vector: writeback clears, a new producer sets (set beats
    // clear), the zero register never goes busy, and flush beats everything.
    always_comb begin
        busy_nxt = busy;
        for (int a = 0; a < DEPTH; a++) begin
            if (wr_hit(we0, waddr0, ADDR_W'(a)) || wr_hit(we1, waddr1, ADDR_W'(a))) begin
                busy_nxt[a] = 1'b0;
            end
            if (busy_set && (busy_addr == ADDR_W'(a))) begin
                busy_nxt[a] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end
    end

    // Scoreboard state plus a registered summary of the post-update vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_any_r <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            busy_any_r <= |busy_nxt;
        end
    end

    assign busy_any = busy_any_r;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;
        logic              rbsy;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        // Read mux: zero register, then port 1 bypass, then port 0 bypass,
        // then storage; the bypass paths are masked while reset is asserted.
        always_comb begin
            rdat = regs[ra];
            if (!reset) begin
                rdat = '0;
            end else if (is_zero_reg(ra)) begin
                rdat = '0;
            end else if (wr_hit(we1, waddr1, ra)) begin
                rdat = wdata1;
            end else if (wr_hit(we0, waddr0, ra)) begin
                rdat = wdata0;
            end
        end

        // Hazard flag: pending, unless the producer is writing back right now.
        always_comb begin
            rbsy = reset && busy[ra]
                   && !wr_hit(we0, waddr0, ra)
                   && !wr_hit(we1, waddr1, ra);
        end

        assign rd_data[k*DATA_W +: DATA_W] = rdat;
        assign rd_busy[k]                  = rbsy;
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Randomised plus directed bench for regfile_mp_scoreboard, checked against
// an array-based reference model of the register file and scoreboard.
module tb_regfile_mp_scoreboard;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int ZERO_REG = 1;
    localparam int DEPTH    = 1 << ADDR_W;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we0, we1, busy_set, flush;
    logic [ADDR_W-1:0]        waddr0, waddr1, busy_addr;
    logic [DATA_W-1:0]        wdata0, wdata1;
    logic                     busy_any;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [DATA_W-1:0] m_mem  [DEPTH];
    bit                m_busy [DEPTH];
    bit                m_any;

    regfile_mp_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .flush(flush), .busy_any(busy_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] port_data(input int k);
        return rd_data[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [ADDR_W-1:0] port_addr(input int k);
        return rd_addr[k*ADDR_W +: ADDR_W];
    endfunction

    // What a read of address a must return this cycle.
    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
        if (!reset)                          return '0;
        if (ZERO_REG != 0 && a == 0)         return '0;
        if (we1 && waddr1 == a)              return wdata1;
        if (we0 && waddr0 == a)              return wdata0;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
        if (!reset) return 1'b0;
        if ((we0 && waddr0 == a) || (we1 && waddr1 == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 0;
        end
        m_any = 0;
    endtask

    // Model state change at a clock edge, from the rules for writes and busy bits.
    task automatic model_edge();
        bit any;
        if (!reset) begin
            model_clear();
            return;
        end
        if (we0 && !(ZERO_REG != 0 && waddr0 == 0)) m_mem[waddr0] = wdata0;
        if (we1 && !(ZERO_REG != 0 && waddr1 == 0)) m_mem[waddr1] = wdata1;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
        end else begin
            if (we0) m_busy[waddr0] = 0;
            if (we1) m_busy[waddr1] = 0;
            if (busy_set && !(ZERO_REG != 0 && busy_addr == 0)) m_busy[busy_addr] = 1;
        end
        any = 0;
        for (int i = 0; i < DEPTH; i++) any |= m_busy[i];
        m_any = any;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; busy_set = 0; flush = 0;
        waddr0 = '0; waddr1 = '0; busy_addr = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    // Inputs are already driven (just after a falling edge): check every
    // output against the model, then take one rising edge.
    task automatic step();
        #1;
        for (int k = 0; k < NUM_RD; k++) begin
            check($sformatf("rd_data[%0d]", k), 64'(port_data(k)), 64'(exp_data(port_addr(k))));
            check($sformatf("rd_busy[%0d]", k), 64'(rd_busy[k]), 64'(exp_busy(port_addr(k))));
        end
        check("busy_any", 64'(busy_any), 64'(m_any));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rd_addr = '0;
        reset   = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy_any", 64'(busy_any), 64'd0);
        check("reset_rd_data0", 64'(port_data(0)), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Every register reads zero and not busy after reset
        for (int r = 0; r < DEPTH; r++) begin
            for (int k = 0; k < NUM_RD; k++) set_rd(k, (r + k) % DEPTH);
            step();
        end

        // Basic write: bypass in the write cycle, storage afterwards
        we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; set_rd(0, 5); set_rd(1, 0);
        #1 check("basic_bypass", 64'(port_data(0)), 64'hDEADBEEF);
        step();
        idle();
        #1 check("basic_stored", 64'(port_data(0)), 64'hDEADBEEF);
        step();
        we0 = 1; waddr0 = 0; wdata0 = 32'h1234; set_rd(0, 0);
        #1 check("zero_bypass", 64'(port_data(0)), 64'd0);
        step();
        idle();
        #1 check("zero_stored", 64'(port_data(0)), 64'd0);
        step();

        // Dual-write collision: port 1 wins
        we0 = 1; we1 = 1; waddr0 = 7; waddr1 = 7; wdata0 = 32'h11; wdata1 = 32'h22; set_rd(0, 7);
        #1 check("collide_bypass", 64'(port_data(0)), 64'h22);
        step();
        idle();
        #1 check("collide_stored", 64'(port_data(0)), 64'h22);
        step();
        we1 = 1; waddr1 = 9; wdata1 = 32'h99;
        step();
        idle();
        waddr0 = 9; wdata0 = 32'hFFFF_FFFF; set_rd(0, 9);
        #1 check("no_bypass_we_low", 64'(port_data(0)), 64'h99);
        step();

        // Scoreboard set, same-cycle writeback clear, busy_any latency
        idle(); busy_set = 1; busy_addr = 3; set_rd(0, 3);
        #1 check("set_not_visible_yet", 64'(rd_busy[0]), 64'd0);
        step();
        idle();
        #1 check("busy_after_set", 64'(rd_busy[0]), 64'd1);
        check("busy_any_after_set", 64'(busy_any), 64'd1);
        we1 = 1; waddr1 = 3; wdata1 = 32'h33;
        #1 check("busy_masked_by_wb", 64'(rd_busy[0]), 64'd0);
        step();
        idle();
        #1 check("busy_cleared", 64'(rd_busy[0]), 64'd0);
        check("busy_any_cleared", 64'(busy_any), 64'd0);
        step();

        // Set beats clear; flush beats set; zero register never busy
        busy_set = 1; busy_addr = 4; we0 = 1; waddr0 = 4; wdata0 = 32'h44; set_rd(0, 4);
        step();
        idle();
        #1 check("set_wins_race", 64'(rd_busy[0]), 64'd1);
        step();
        busy_set = 1; busy_addr = 6; flush = 1; set_rd(1, 6);
        step();
        idle();
        #1 check("flush_any", 64'(busy_any), 64'd0);
        check("flush_r4", 64'(rd_busy[0]), 64'd0);
        check("flush_r6", 64'(rd_busy[1]), 64'd0);
        step();
        busy_set = 1; busy_addr = 0; set_rd(0, 0);
        step();
        idle();
        #1 check("zero_never_busy", 64'(rd_busy[0]), 64'd0);
        check("zero_busy_any", 64'(busy_any), 64'd0);
        step();

        // Randomised traffic, addresses biased to a small window for collisions
        for (int n = 0; n < 3000; n++) begin
            bit narrow;
            narrow    = ($urandom_range(0, 3) != 0);
            we0       = $urandom_range(0, 1);
            we1       = $urandom_range(0, 2) == 0;
            busy_set  = $urandom_range(0, 1);
            flush     = $urandom_range(0, 40) == 0;
            waddr0    = narrow ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            waddr1    = narrow ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            busy_addr = narrow ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            wdata0    = $urandom;
            wdata1    = $urandom;
            for (int k = 0; k < NUM_RD; k++)
                set_rd(k, narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1)));
            step();
        end

        // Asynchronous reset in the middle of operation
        idle(); we0 = 1; waddr0 = 10; wdata0 = 32'hA5A5_0010; busy_set = 1; busy_addr = 11;
        step();
        idle(); set_rd(0, 10); set_rd(1, 11);
        #1 check("pre_reset_data", 64'(port_data(0)), 64'hA5A5_0010);
        check("pre_reset_busy", 64'(rd_busy[1]), 64'd1);
        #1 reset = 1'b0;
        #1 check("async_rd_data", 64'(port_data(0)), 64'd0);
        check("async_rd_busy", 64'(rd_busy[1]), 64'd0);
        check("async_busy_any", 64'(busy_any), 64'd0);
        we0 = 1; waddr0 = 12; wdata0 = 32'hCAFE; busy_set = 1; busy_addr = 12; set_rd(0, 12);
        #1 check("in_reset_no_bypass", 64'(port_data(0)), 64'd0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset = 1'b1;
        idle();
        for (int r = 8; r < 16; r++) begin
            set_rd(0, r); set_rd(1, r + 8);
            step();
        end
        check("post_reset_r12", 64'(m_mem[12]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
